// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// fetch_unit_pkg : shared widths, reset defaults and FSM encoding for fetch_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [PC_WIDTH-1:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [PC_WIDTH-1:0] PC_STEP_DEFAULT  = 32'd4;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_HALT  = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pc_incrementer.sv
// ============================================================================
// pc_incrementer : fixed-step unsigned adder, wraps modulo 2^WIDTH
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_incrementer #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] STEP  = 4
) (
  input  logic [WIDTH-1:0] i_value,
  output logic [WIDTH-1:0] o_sum
);

  assign o_sum = i_value + STEP;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC register, instruction-memory read handshake and retire logic
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] PC_RESET = PC_RESET_DEFAULT,
  parameter logic [PC_WIDTH-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [PC_WIDTH-1:0]    BRANCH_TARGET,
  input  logic                   TAKE_BRANCH,
  input  logic                   STALL,
  output logic [PC_WIDTH-1:0]    IMEM_ADDRESS,
  output logic                   IMEM_READ,
  input  logic [INSTR_WIDTH-1:0] IMEM_READDATA,
  input  logic                   IMEM_BUSYWAIT,
  output logic [PC_WIDTH-1:0]    PC,
  output logic [PC_WIDTH-1:0]    PC_PLUS4,
  output logic [INSTR_WIDTH-1:0] INSTRUCTION,
  output logic                   INSTR_VALID,
  output logic [31:0]            INSTR_COUNT,
  output logic                   FAULT
);

  state_e                   state_q, state_d;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
  logic [31:0]              count_q, count_d;
  logic                     fault_q, fault_d;
  logic [PC_WIDTH-1:0]      pc_plus_step;
  logic [31:0]              count_plus_one;

  pc_incrementer #(
    .WIDTH (PC_WIDTH),
    .STEP  (PC_STEP)
  ) u_pc_inc (
    .i_value (pc_q),
    .o_sum   (pc_plus_step)
  );

  pc_incrementer #(
    .WIDTH (32),
    .STEP  (32'd1)
  ) u_count_inc (
    .i_value (count_q),
    .o_sum   (count_plus_one)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    fault_d = fault_q;
    case (state_q)
      S_FETCH: begin
        if (!IMEM_BUSYWAIT) begin
          instr_d = IMEM_READDATA;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // STALL outranks the branch: nothing is sampled until the retiring edge
        if (!STALL) begin
          count_d = count_plus_one;
          if (TAKE_BRANCH) begin
            pc_d = BRANCH_TARGET;
            if (BRANCH_TARGET[1:0] != 2'b00) begin
              fault_d = 1'b1;
              state_d = S_HALT;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            pc_d    = pc_plus_step;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      count_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  assign IMEM_ADDRESS = pc_q;
  assign IMEM_READ    = (state_q == S_FETCH);
  assign INSTR_VALID  = (state_q == S_EXEC);
  assign PC           = pc_q;
  assign PC_PLUS4     = pc_plus_step;
  assign INSTRUCTION  = instr_q;
  assign INSTR_COUNT  = count_q;
  assign FAULT        = fault_q;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and program-counter stage of the single-cycle 8-bit CPU. Holds the PC, runs the read handshake with instruction memory, and presents one latched 32-bit instruction per fetch to the decode/control logic. Produces PC+4 for the branch/jump offset adder. Consumes that adder's target and the branch-select result to choose the next PC. Freezes while data memory reports busy-wait.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential instruction.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high; clears all state immediately, independent of CLK.
- BRANCH_TARGET  in  32  next-PC candidate from the offset adder (PC+4 + offset×4).
- TAKE_BRANCH  in  1  1 = branch/jump taken (branch-select output OR jump).
- STALL  in  1  data-memory busy-wait; holds the current instruction.
- IMEM_ADDRESS  out  32  byte address of the instruction being fetched (= PC).
- IMEM_READ  out  1  read request to instruction memory.
- IMEM_READDATA  in  32  instruction word from memory.
- IMEM_BUSYWAIT  in  1  1 = memory not ready; READDATA is valid on any edge where READ=1 and BUSYWAIT=0.
- PC  out  32  address of the instruction currently presented.
- PC_PLUS4  out  32  PC + PC_STEP, combinational, feeds the offset adder.
- INSTRUCTION  out  32  latched instruction word.
- INSTR_VALID  out  1  INSTRUCTION is valid and executing this cycle.
- INSTR_COUNT  out  32  number of retired instructions, wraps modulo 2^32.
- FAULT  out  1  sticky misaligned-target flag.

## Operation
- States: S_FETCH, S_EXEC, S_HALT. Reset state is S_FETCH.
- S_FETCH:
  - IMEM_READ=1, IMEM_ADDRESS=PC.
  - On an edge with IMEM_BUSYWAIT=0: INSTRUCTION <= IMEM_READDATA, go to S_EXEC.
  - Otherwise stay in S_FETCH with READ and ADDRESS held stable.
- S_EXEC:
  - IMEM_READ=0, INSTR_VALID=1.
  - On an edge with STALL=1: no change; INSTR_VALID stays 1 and the instruction is not retired.
  - On an edge with STALL=0: the instruction retires.
    - INSTR_COUNT increments.
    - PC <= TAKE_BRANCH ? BRANCH_TARGET : PC_PLUS4.
    - Go to S_FETCH.
- Misalignment check: if TAKE_BRANCH=1 and BRANCH_TARGET[1:0]≠0 at retire, then:
  - FAULT <= 1, PC <= BRANCH_TARGET, go to S_HALT.
  - INSTR_COUNT still increments for the faulting instruction.
- S_HALT:
  - IMEM_READ=0, INSTR_VALID=0.
  - All registers frozen until RESET.
- Arithmetic:
  - PC_PLUS4 is 32-bit unsigned and wraps: 32'hFFFF_FFFC → 32'h0000_0000.
  - BRANCH_TARGET is used as given, with no sign handling here.
- Simultaneous events:
  - STALL takes priority over TAKE_BRANCH, so no PC update while stalled.
  - STALL is ignored outside S_EXEC.
  - TAKE_BRANCH and BRANCH_TARGET are sampled only on the retiring edge.

## Timing
- Reset values:
  - PC=PC_RESET, PC_PLUS4=PC_RESET+4.
  - INSTRUCTION=0, INSTR_VALID=0, INSTR_COUNT=0, FAULT=0.
  - IMEM_READ=1 (S_FETCH), IMEM_ADDRESS=PC_RESET.
- Reset asserted mid-fetch or mid-stall aborts the operation in the same cycle. The first request after release is to PC_RESET.
- Minimum fetch latency: memory ready on the first edge gives FETCH (1 cycle) then EXEC (1 cycle). That is 2 cycles per instruction.
- Each memory busy-wait cycle adds 1. Each STALL cycle adds 1.
- All outputs except PC_PLUS4 are registered or decoded from registered state, so they are glitch-free within a cycle.
- IMEM_ADDRESS never changes while IMEM_READ=1.

## Structure
- Shared package holds:
  - state encoding S_FETCH=2'b00, S_EXEC=2'b01, S_HALT=2'b10;
  - PC_WIDTH=32 and INSTR_WIDTH=32;
  - default PC_RESET and PC_STEP.
- One sub-module: pc_incrementer. It is a 32-bit PC + PC_STEP producing PC_PLUS4 and is reused for the count increment logic pattern.
- The FSM, PC register, instruction latch, counter and fault flag live in fetch_unit itself.

## Test plan
- Reset, then memory ready immediately, no branches, for 3 instructions → IMEM_ADDRESS sequence 0, 4, 8; INSTR_VALID high every 2nd cycle; INSTR_COUNT=3.
- IMEM_BUSYWAIT=1 for 3 edges on the fetch at PC=4 → READ and ADDRESS=4 held stable for 4 cycles; INSTRUCTION updates only on the ready edge.
- In S_EXEC, STALL=1 for 2 cycles with TAKE_BRANCH=1 and target 0x20 → PC stays and INSTR_VALID stays 1 for 3 cycles; next fetch address is 0x20; count +1 only.
- Taken branch to 0x0000_0022 → FAULT=1, PC=0x22, state S_HALT, IMEM_READ=0 indefinitely; RESET clears FAULT and PC=0.
- PC preloaded to 0xFFFF_FFFC via taken branch, then sequential retire → next fetch address 0x0000_0000.
- RESET asserted asynchronously between edges mid-busy-wait → outputs reach reset values before the next edge; first fetch after release is address 0.
